imem_loader: RTL and testbench
==============================

# imem_loader

Byte-serial program loader that fills the core's instruction memory before execution. Accepts a length-prefixed little-endian byte stream over a valid/ready handshake, assembles 32-bit instruction words, and issues one-cycle write strobes into the instruction memory's write port. Holds the core in reset (`core_hold`) until the image is fully written, then releases it.

## Interface
Parameters:
- `ADDR_W`, 10: word-address width of instruction memory; capacity is 2^ADDR_W words.
- `BASE_ADDR`, 0: word address of the first loaded instruction.

Ports:
- `clk`  in  1  system clock; one clock domain.
- `rst`  in  1  reset; synchronous and active-high.
- `start`  in  1  single-cycle load request; honoured only in IDLE, DONE, ERR.
- `in_valid`  in  1  byte-stream valid.
- `in_data`  in  8  byte-stream data.
- `in_ready`  out  1  loader accepts a byte this cycle; a byte transfers when `in_valid && in_ready` at a rising edge.
- `wr_en`  out  1  instruction-memory write strobe, one cycle per word.
- `wr_addr`  out  ADDR_W  word write address.
- `wr_data`  out  32  assembled instruction word.
- `core_hold`  out  1  1 = core held in reset.
- `done`  out  1  image loaded, core released.
- `err`  out  1  load aborted.

## Operation
- States: IDLE, LEN0, LEN1, DATA, CSUM (only with macro), DONE, ERR.
- IDLE: `in_ready`=0; `start` -> LEN0.
- LEN0/LEN1: accept word count N, low byte first (16-bit).
- After LEN1: N=0 -> DONE (or CSUM if enabled); N > 2^ADDR_W -> ERR; else DATA.
- DATA: bytes little-endian within a word: 1st byte -> `wr_data[7:0]`, 4th -> `wr_data[31:24]`. After the 4th byte, word index k (0..N-1) is written at `wr_addr` = BASE_ADDR + k, truncated to ADDR_W bits (wraps modulo 2^ADDR_W). After word N-1 -> DONE (or CSUM).
- DONE: `done`=1, `core_hold`=0. `start` -> LEN0, `core_hold`=1 and `done`=0 the next cycle.
- ERR: `err`=1, `core_hold`=1, `in_ready`=0; only `start` or `rst` exits (`start` -> LEN0, `err` cleared).
- `start` in LEN0/LEN1/DATA/CSUM is ignored; the load in progress continues.
- `in_valid` low stalls the FSM indefinitely; no timeout.
- `in_data` is ignored when no handshake occurs.

## Timing
- Reset values: state IDLE, `in_ready`=0, `wr_en`=0, `wr_addr`=0, `wr_data`=0, `core_hold`=1, `done`=0, `err`=0, byte counter and word index 0.
- `in_ready` decodes from the registered state only: 1 in LEN0, LEN1, DATA, CSUM. It never depends on `in_valid`.
- Throughput: 1 byte/cycle sustained; no bubbles between words.
- `wr_en`, `wr_addr` and `wr_data` are registered. `wr_en` is high exactly in the cycle after the 4th-byte handshake, with address and data stable in that cycle. `wr_data` holds its value between strobes.
- Without checksum, `done` rises and `core_hold` falls the cycle after the final `wr_en` cycle, so the last write completes before release.
- With N=0, DONE is entered at the edge after the LEN1 handshake.
- `rst` mid-load has priority over everything. It returns all outputs to reset values at that edge, discards any partial word, issues no `wr_en`, and leaves `core_hold`=1.

## Configuration
- Macro: `IMEM_LOADER_CHECKSUM_EN`.
- Defined: after the last data word (or directly after LEN1 when N=0), the FSM enters CSUM and accepts one byte.
  - The expected value is the 8-bit modulo-256 sum of all data bytes; length bytes are excluded.
  - Match -> DONE the edge after the handshake. Mismatch -> ERR.
  - The final word's `wr_en` still occurs; instruction memory contents are not rolled back on mismatch.
- Undefined: no CSUM state, no accumulator; DATA goes straight to DONE.

## Test plan
- Reset, then `start`; stream 02 00, 13 00 00 00, 93 00 10 00 -> `wr_en` at addr 0 data 0x00000013, then addr 1 data 0x00100093; `done`=1 and `core_hold`=0 one cycle after the second strobe.
- Same stream with `in_valid` deasserted randomly for 0-3 cycles between bytes -> identical writes and no extra `wr_en`; `in_ready` stays 1 throughout DATA.
- Length 00 00 -> no `wr_en`; `done`=1 at the edge after the LEN1 handshake.
- Length with N = 2^ADDR_W + 1 (0x0401 for ADDR_W=10) -> `err`=1, `core_hold`=1, `in_ready`=0; a following `start` clears `err`.
- `rst` asserted after 2 of 4 bytes of word 0 -> no `wr_en`, all outputs at reset values; a fresh load then writes correctly from addr BASE_ADDR.
- With `IMEM_LOADER_CHECKSUM_EN`: stream 01 00, 13 00 00 00, then checksum 13 -> `done`. With checksum 14 instead -> `err`=1 and `core_hold`=1, while the write of 0x00000013 at addr 0 still occurs.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader
//
// Byte-serial program loader for the core's instruction memory. A load is a
// 16-bit little-endian word count N followed by N little-endian 32-bit
// instruction words. Each assembled word is written with a one-cycle strobe.
// The core is held in reset until the whole image has been written.
//
// Optional feature: define IMEM_LOADER_CHECKSUM_EN to require a trailing
// checksum byte. This byte is the modulo-256 sum of all data bytes. A mismatch
// aborts the load into the error state.
//
// Parameters:
//   ADDR_W     word-address width of instruction memory (capacity 2^ADDR_W)
//   BASE_ADDR  word address of the first loaded instruction
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   start      load request, honoured in IDLE, DONE and ERR only
//   in_valid   byte-stream valid
//   in_data    byte-stream data
//   in_ready   loader accepts a byte this cycle (decoded from state only)
//   wr_en      instruction-memory write strobe, one cycle per word
//   wr_addr    word write address
//   wr_data    assembled instruction word (held between strobes)
//   core_hold  1 = core held in reset
//   done       image loaded, core released
//   err        load aborted
module imem_loader #(
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              core_hold,
    output logic              done,
    output logic              err
);

`ifdef IMEM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LEN0 = 3'd1,
        S_LEN1 = 3'd2,
        S_DATA = 3'd3,
        S_CSUM = 3'd4,
        S_DONE = 3'd5,
        S_ERR  = 3'd6
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LEN0 = 3'd1,
        S_LEN1 = 3'd2,
        S_DATA = 3'd3,
        S_DONE = 3'd5,
        S_ERR  = 3'd6
    } state_t;
`endif

    // Largest legal word count; 33 bits so that any ADDR_W up to 32 fits.
    localparam logic [32:0]       CAP_WORDS = 33'd1 << ADDR_W;
    localparam logic [ADDR_W-1:0] BASE_W    = ADDR_W'(BASE_ADDR);

    state_t            state_r;
    logic [7:0]        len_lo_r;
    logic [15:0]       word_cnt_r;
    logic [15:0]       word_idx_r;
    logic [1:0]        byte_cnt_r;
    logic [23:0]       part_r;
    logic [ADDR_W-1:0] addr_r;
    logic              wr_en_r;
    logic [ADDR_W-1:0] wr_addr_r;
    logic [31:0]       wr_data_r;
    logic              core_hold_r;
    logic              done_r;
    logic              err_r;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]        csum_r;
`endif

    logic              in_ready_s;
    logic              hs_s;
    logic [15:0]       len_full_s;
    logic              last_word_s;
    logic              restart_s;

    // in_ready is a pure decode of the registered state, never of in_valid.
`ifdef IMEM_LOADER_CHECKSUM_EN
    assign in_ready_s = (state_r == S_LEN0) || (state_r == S_LEN1) ||
                        (state_r == S_DATA) || (state_r == S_CSUM);
`else
    assign in_ready_s = (state_r == S_LEN0) || (state_r == S_LEN1) ||
                        (state_r == S_DATA);
`endif

    assign hs_s        = in_valid && in_ready_s;
    assign len_full_s  = {in_data, len_lo_r};
    assign last_word_s = ((word_idx_r + 16'd1) == word_cnt_r);
    assign restart_s   = start && ((state_r == S_IDLE) || (state_r == S_DONE) ||
                                   (state_r == S_ERR));

    assign in_ready  = in_ready_s;
    assign wr_en     = wr_en_r;
    assign wr_addr   = wr_addr_r;
    assign wr_data   = wr_data_r;
    assign core_hold = core_hold_r;
    assign done      = done_r;
    assign err       = err_r;

    // Loader FSM: length capture, word assembly, write strobes and status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= S_IDLE;
            len_lo_r    <= 8'd0;
            word_cnt_r  <= 16'd0;
            word_idx_r  <= 16'd0;
            byte_cnt_r  <= 2'd0;
            part_r      <= 24'd0;
            addr_r      <= BASE_W;
            wr_en_r     <= 1'b0;
            wr_addr_r   <= {ADDR_W{1'b0}};
            wr_data_r   <= 32'd0;
            core_hold_r <= 1'b1;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_r      <= 8'd0;
`endif
        end else begin
            wr_en_r <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        state_r <= S_LEN0;
                    end
                end
                S_LEN0: begin
                    if (hs_s) begin
                        len_lo_r <= in_data;
                        state_r  <= S_LEN1;
                    end
                end
                S_LEN1: begin
                    if (hs_s) begin
                        word_cnt_r <= len_full_s;
                        if (len_full_s == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                            state_r     <= S_CSUM;
`else
                            // Nothing to write, so release the core at this very edge.
                            state_r     <= S_DONE;
                            done_r      <= 1'b1;
                            core_hold_r <= 1'b0;
`endif
                        end else if ({17'd0, len_full_s} > CAP_WORDS) begin
                            state_r <= S_ERR;
                            err_r   <= 1'b1;
                        end else begin
                            state_r <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (hs_s) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum_r <= csum_r + in_data;
`endif
                        byte_cnt_r <= byte_cnt_r + 2'd1;
                        case (byte_cnt_r)
                            2'd0: part_r[7:0]   <= in_data;
                            2'd1: part_r[15:8]  <= in_data;
                            2'd2: part_r[23:16] <= in_data;
                            2'd3: begin
                                wr_en_r    <= 1'b1;
                                wr_addr_r  <= addr_r;
                                wr_data_r  <= {in_data, part_r};
                                addr_r     <= addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                                word_idx_r <= word_idx_r + 16'd1;
                                if (last_word_s) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                                    state_r <= S_CSUM;
`else
                                    // done/core_hold follow one cycle later in
                                    // DONE, after this final strobe has landed.
                                    state_r <= S_DONE;
`endif
                                end
                            end
                            default: byte_cnt_r <= 2'd0;
                        endcase
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                S_CSUM: begin
                    if (hs_s) begin
                        if (in_data == csum_r) begin
                            state_r     <= S_DONE;
                            done_r      <= 1'b1;
                            core_hold_r <= 1'b0;
                        end else begin
                            state_r <= S_ERR;
                            err_r   <= 1'b1;
                        end
                    end
                end
`endif
                S_DONE: begin
                    if (start) begin
                        state_r     <= S_LEN0;
                        done_r      <= 1'b0;
                        core_hold_r <= 1'b1;
                    end else begin
                        done_r      <= 1'b1;
                        core_hold_r <= 1'b0;
                    end
                end
                S_ERR: begin
                    if (start) begin
                        state_r <= S_LEN0;
                        err_r   <= 1'b0;
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase

            // A new load always starts from a clean word/byte position.
            if (restart_s) begin
                word_idx_r <= 16'd0;
                byte_cnt_r <= 2'd0;
                addr_r     <= BASE_W;
`ifdef IMEM_LOADER_CHECKSUM_EN
                csum_r     <= 8'd0;
`endif
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader
//
// Directed bench for imem_loader (ADDR_W=10, BASE_ADDR=0). A cycle table drives
// the basic two-word load and checks every output after each edge. Hand-written
// sequences then cover these cases:
//   - a stalled stream with random gaps
//   - a zero-length image
//   - an oversize length
//   - a reset in the middle of a word
// The checksum cases are included when IMEM_LOADER_CHECKSUM_EN is defined.
module tb_imem_loader;

    logic        clk;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        wr_en;
    logic [9:0]  wr_addr;
    logic [31:0] wr_data;
    logic        core_hold;
    logic        done;
    logic        err;

    int checks;
    int passes;

    typedef struct {
        logic        start;
        logic        valid;
        logic [7:0]  data;
        logic        e_ready;
        logic        e_wr;
        logic [9:0]  e_addr;
        logic [31:0] e_data;
        logic        e_hold;
        logic        e_done;
        logic        e_err;
    } vec_t;

    vec_t       vecs[13];
    logic [7:0] stall_bytes[10];
    logic [31:0] exp_words[2];

    imem_loader #(.ADDR_W(10), .BASE_ADDR(0)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .core_hold (core_hold),
        .done      (done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end else begin
            passes++;
        end
    endtask

    // Idle for 'gap' cycles while in a ready state, then hand over one byte.
    task automatic send(input logic [7:0] b, input int gap);
        repeat (gap) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            step();
            chk("gap_in_ready", {31'd0, in_ready}, 32'd1);
            chk("gap_wr_en", {31'd0, wr_en}, 32'd0);
        end
        in_valid = 1'b1;
        in_data  = b;
        step();
        in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
        chk({tag, "_wr_en"}, {31'd0, wr_en}, 32'd0);
        chk({tag, "_wr_addr"}, {22'd0, wr_addr}, 32'd0);
        chk({tag, "_wr_data"}, wr_data, 32'd0);
        chk({tag, "_core_hold"}, {31'd0, core_hold}, 32'd1);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_err"}, {31'd0, err}, 32'd0);
    endtask

    initial begin
        checks   = 0;
        passes   = 0;
        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;

        //            start valid data    rdy  wr   addr    data           hold done err
        vecs[0]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 10'd0, 32'h00000000, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 8'h02, 1'b1, 1'b0, 10'd0, 32'h00000000, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 10'd0, 32'h00000000, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 8'h13, 1'b1, 1'b0, 10'd0, 32'h00000000, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 10'd0, 32'h00000000, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 10'd0, 32'h00000000, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 10'd0, 32'h00000013, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 8'h93, 1'b1, 1'b0, 10'd0, 32'h00000013, 1'b1, 1'b0, 1'b0};
        // start mid-load must be ignored
        vecs[8]  = '{1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 10'd0, 32'h00000013, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 8'h10, 1'b1, 1'b0, 10'd0, 32'h00000013, 1'b1, 1'b0, 1'b0};
`ifdef IMEM_LOADER_CHECKSUM_EN
        vecs[10] = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 10'd1, 32'h00100093, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 8'hB6, 1'b0, 1'b0, 10'd1, 32'h00100093, 1'b0, 1'b1, 1'b0};
`else
        vecs[10] = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 10'd1, 32'h00100093, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 8'h5A, 1'b0, 1'b0, 10'd1, 32'h00100093, 1'b0, 1'b1, 1'b0};
`endif
        vecs[12] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 10'd1, 32'h00100093, 1'b0, 1'b1, 1'b0};

        stall_bytes = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        exp_words   = '{32'h00000013, 32'h00100093};

        // Reset state
        step();
        step();
        chk_reset_vals("reset");
        rst = 1'b0;

        // Basic two-word load, cycle by cycle
        for (int i = 0; i < 13; i++) begin
            start    = vecs[i].start;
            in_valid = vecs[i].valid;
            in_data  = vecs[i].data;
            step();
            chk("tbl_in_ready", {31'd0, in_ready}, {31'd0, vecs[i].e_ready});
            chk("tbl_wr_en", {31'd0, wr_en}, {31'd0, vecs[i].e_wr});
            chk("tbl_wr_addr", {22'd0, wr_addr}, {22'd0, vecs[i].e_addr});
            chk("tbl_wr_data", wr_data, vecs[i].e_data);
            chk("tbl_core_hold", {31'd0, core_hold}, {31'd0, vecs[i].e_hold});
            chk("tbl_done", {31'd0, done}, {31'd0, vecs[i].e_done});
            chk("tbl_err", {31'd0, err}, {31'd0, vecs[i].e_err});
        end
        start    = 1'b0;
        in_valid = 1'b0;

        // Same image with random stalls, restarted from DONE
        pulse_start();
        chk("restart_hold", {31'd0, core_hold}, 32'd1);
        chk("restart_done", {31'd0, done}, 32'd0);
        for (int i = 0; i < 10; i++) begin
            send(stall_bytes[i], int'($urandom_range(0, 3)));
            if (i >= 2) begin
                chk("stall_wr_en", {31'd0, wr_en}, (((i - 2) % 4) == 3) ? 32'd1 : 32'd0);
                if (((i - 2) % 4) == 3) begin
                    chk("stall_wr_addr", {22'd0, wr_addr}, 32'((i - 2) / 4));
                    chk("stall_wr_data", wr_data, exp_words[(i - 2) / 4]);
                end
            end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        send(8'hB6, int'($urandom_range(0, 3)));
`else
        step();
`endif
        chk("stall_done", {31'd0, done}, 32'd1);
        chk("stall_hold", {31'd0, core_hold}, 32'd0);
        chk("stall_no_extra_wr", {31'd0, wr_en}, 32'd0);

        // Zero-length image
        pulse_start();
        send(8'h00, 0);
        send(8'h00, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        chk("n0_csum_ready", {31'd0, in_ready}, 32'd1);
        send(8'h00, 0);
`endif
        chk("n0_done", {31'd0, done}, 32'd1);
        chk("n0_hold", {31'd0, core_hold}, 32'd0);
        chk("n0_wr_en", {31'd0, wr_en}, 32'd0);

        // Oversize length 0x0401
        pulse_start();
        send(8'h01, 0);
        send(8'h04, 0);
        chk("ovf_err", {31'd0, err}, 32'd1);
        chk("ovf_hold", {31'd0, core_hold}, 32'd1);
        chk("ovf_ready", {31'd0, in_ready}, 32'd0);
        chk("ovf_done", {31'd0, done}, 32'd0);
        in_valid = 1'b1;
        in_data  = 8'h55;
        step();
        step();
        in_valid = 1'b0;
        chk("ovf_sticky_err", {31'd0, err}, 32'd1);
        chk("ovf_sticky_wr", {31'd0, wr_en}, 32'd0);
        pulse_start();
        chk("ovf_clear_err", {31'd0, err}, 32'd0);
        chk("ovf_clear_ready", {31'd0, in_ready}, 32'd1);
        chk("ovf_clear_hold", {31'd0, core_hold}, 32'd1);

        // Reset after two bytes of word 0
        send(8'h01, 0);
        send(8'h00, 0);
        send(8'h13, 0);
        send(8'h00, 0);
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h77;
        step();
        rst      = 1'b0;
        in_valid = 1'b0;
        chk_reset_vals("midrst");
        step();
        chk("midrst_idle_ready", {31'd0, in_ready}, 32'd0);
        chk("midrst_idle_wr", {31'd0, wr_en}, 32'd0);
        pulse_start();
        send(8'h01, 0);
        send(8'h00, 0);
        send(8'hAB, 0);
        send(8'hCD, 0);
        send(8'hEF, 0);
        send(8'h12, 0);
        chk("fresh_wr_en", {31'd0, wr_en}, 32'd1);
        chk("fresh_wr_addr", {22'd0, wr_addr}, 32'd0);
        chk("fresh_wr_data", wr_data, 32'h12EFCDAB);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send(8'h79, 0);
`else
        step();
`endif
        chk("fresh_done", {31'd0, done}, 32'd1);
        chk("fresh_hold", {31'd0, core_hold}, 32'd0);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Matching checksum
        pulse_start();
        send(8'h01, 0);
        send(8'h00, 0);
        send(8'h13, 0);
        send(8'h00, 0);
        send(8'h00, 0);
        send(8'h00, 0);
        chk("cs_ok_wr_en", {31'd0, wr_en}, 32'd1);
        chk("cs_ok_wr_data", wr_data, 32'h00000013);
        send(8'h13, 0);
        chk("cs_ok_done", {31'd0, done}, 32'd1);
        chk("cs_ok_err", {31'd0, err}, 32'd0);

        // Wrong checksum: the write still happens, then abort
        pulse_start();
        send(8'h01, 0);
        send(8'h00, 0);
        send(8'h13, 0);
        send(8'h00, 0);
        send(8'h00, 0);
        send(8'h00, 0);
        chk("cs_bad_wr_en", {31'd0, wr_en}, 32'd1);
        chk("cs_bad_wr_addr", {22'd0, wr_addr}, 32'd0);
        chk("cs_bad_wr_data", wr_data, 32'h00000013);
        send(8'h14, 0);
        chk("cs_bad_err", {31'd0, err}, 32'd1);
        chk("cs_bad_hold", {31'd0, core_hold}, 32'd1);
        chk("cs_bad_done", {31'd0, done}, 32'd0);
        chk("cs_bad_ready", {31'd0, in_ready}, 32'd0);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
